// File: rtl/key_schedule.sv
// RC4 key-scheduling stage: fills the shared S memory with the identity
// permutation, then performs the 256 KSA swaps using a 3-byte secret key.
module key_schedule (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q_data,
  output logic        finish,
  output logic        ksa_mem_handler,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wen
);

  typedef enum logic [3:0] {
    IDLE, INIT, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;

  // Byte 0 of the key is the most significant byte.
  function automatic logic [7:0] key_byte(input logic [23:0] key,
                                          input logic [1:0]  idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      kidx_q  <= 2'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
        end
      end
      INIT: begin
        // i wraps from 255 back to 0, ready for the first swap iteration.
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = READ_I;
      end
      READ_I: state_d = WAIT_I;
      WAIT_I: begin
        si_d    = q_data;
        j_d     = j_q + q_data + key_byte(secret_key, kidx_q);
        state_d = READ_J;
      end
      READ_J: state_d = WAIT_J;
      WAIT_J: begin
        sj_d    = q_data;
        state_d = WRITE_I;
      end
      WRITE_I: state_d = WRITE_J;
      WRITE_J: begin
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = READ_I;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    finish          = 1'b0;
    ksa_mem_handler = 1'b0;
    address         = 8'd0;
    data            = 8'd0;
    wen             = 1'b0;
    case (state_q)
      INIT: begin
        ksa_mem_handler = 1'b1;
        address         = i_q;
        data            = i_q;
        wen             = 1'b1;
      end
      READ_I, WAIT_I: begin
        ksa_mem_handler = 1'b1;
        address         = i_q;
      end
      READ_J, WAIT_J: begin
        ksa_mem_handler = 1'b1;
        address         = j_q;
      end
      WRITE_I: begin
        ksa_mem_handler = 1'b1;
        address         = i_q;
        data            = sj_q;
        wen             = 1'b1;
      end
      WRITE_J: begin
        ksa_mem_handler = 1'b1;
        address         = j_q;
        data            = si_q;
        wen             = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule with a one-cycle synchronous S-memory model.
module tb_key_schedule;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q_data;
  logic        finish;
  logic        ksa_mem_handler;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wen;

  key_schedule dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .secret_key      (secret_key),
    .q_data          (q_data),
    .finish          (finish),
    .ksa_mem_handler (ksa_mem_handler),
    .address         (address),
    .data            (data),
    .wen             (wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [7:0]  exp_s [256];
  int          cyc = 0;
  int          wr_count = 0;
  logic [15:0] wl_ad [$];
  int          wl_cyc [$];
  int          n_tests = 0;
  int          n_fail = 0;

  // Memory model plus write logger; cyc is the cycle index seen at each edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    q_data <= mem[address];
    if (wen) begin
      mem[address] <= data;
      wr_count     <= wr_count + 1;
      wl_ad.push_back({address, data});
      wl_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compute_model(input logic [23:0] key);
    logic [7:0] jj, kb, t;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    jj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      case (k % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = jj + exp_s[k] + kb;
      t = exp_s[k];
      exp_s[k] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic run_ksa(input logic [23:0] key, output int base);
    int  e0, w0, errs, n;
    bit  ok;
    secret_key = key;
    compute_model(key);
    @(negedge clk);
    start = 1'b1;
    e0    = cyc;
    w0    = wr_count;
    base  = wl_ad.size();
    n  = 0;
    ok = 1'b0;
    while (n < 2500 && !ok) begin
      @(negedge clk);
      n++;
      if (finish) ok = 1'b1;
    end
    if (!ok) begin
      check("finish_timeout", 32'd0, 32'd1);
      start = 1'b0;
      return;
    end
    check("finish_latency", 32'(cyc - e0 - 1), 32'd1792);
    check("write_count", 32'(wr_count - w0), 32'd768);
    check("init_first_cyc", 32'(wl_cyc[base]), 32'(e0 + 1));
    check("init_last_cyc", 32'(wl_cyc[base + 255]), 32'(e0 + 256));
    errs = 0;
    for (int k = 0; k < 256; k++)
      if (wl_ad[base + k] !== {8'(k), 8'(k)}) errs++;
    check("init_content_errs", 32'(errs), 32'd0);
    errs = 0;
    for (int k = 0; k < 256; k++)
      if (mem[k] !== exp_s[k]) errs++;
    check("ram_vs_model_errs", 32'(errs), 32'd0);
    // Holding start high keeps the block parked in DONE.
    w0 = wr_count;
    repeat (5) @(negedge clk);
    check("done_hold_finish", 32'(finish), 32'd1);
    check("done_hold_writes", 32'(wr_count - w0), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("idle_finish", 32'(finish), 32'd0);
    check("idle_handler", 32'(ksa_mem_handler), 32'd0);
  endtask

  initial begin
    int          base, n, w0;
    bit          ok;
    logic [23:0] rk;

    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'd0;
    repeat (3) @(negedge clk);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_handler", 32'(ksa_mem_handler), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wen", 32'(wen), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort in the middle of INIT.
    start = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      @(negedge clk);
      n++;
      if (wen && address == 8'd100) ok = 1'b1;
    end
    check("midinit_reached", 32'(ok), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_wen", 32'(wen), 32'd0);
    check("midrst_handler", 32'(ksa_mem_handler), 32'd0);
    check("midrst_finish", 32'(finish), 32'd0);
    check("midrst_address", 32'(address), 32'd0);
    reset = 1'b0;
    w0 = wr_count;
    repeat (50) @(negedge clk);
    check("idle_no_writes", 32'(wr_count - w0), 32'd0);
    check("idle_no_finish", 32'(finish), 32'd0);

    run_ksa(24'h010203, base);
    if (wl_ad.size() >= base + 262) begin
      check("k123_it0_wr_i", 32'(wl_ad[base + 256]), 32'h0001);
      check("k123_it0_wr_j", 32'(wl_ad[base + 257]), 32'h0100);
      check("k123_it1_wr_i", 32'(wl_ad[base + 258]), 32'h0103);
      check("k123_it1_wr_j", 32'(wl_ad[base + 259]), 32'h0300);
      check("k123_it2_wr_i", 32'(wl_ad[base + 260]), 32'h0208);
      check("k123_it2_wr_j", 32'(wl_ad[base + 261]), 32'h0802);
    end else begin
      check("k123_log_size", 32'(wl_ad.size()), 32'(base + 262));
    end

    run_ksa(24'h000000, base);
    if (wl_ad.size() >= base + 262) begin
      check("k000_it0_wr_i", 32'(wl_ad[base + 256]), 32'h0000);
      check("k000_it0_wr_j", 32'(wl_ad[base + 257]), 32'h0000);
      check("k000_it1_wr_i", 32'(wl_ad[base + 258]), 32'h0101);
      check("k000_it1_wr_j", 32'(wl_ad[base + 259]), 32'h0101);
      check("k000_it2_wr_i", 32'(wl_ad[base + 260]), 32'h0203);
      check("k000_it2_wr_j", 32'(wl_ad[base + 261]), 32'h0302);
    end else begin
      check("k000_log_size", 32'(wl_ad.size()), 32'(base + 262));
    end

    run_ksa(24'hFFFFFF, base);
    rk = 24'($urandom);
    run_ksa(rk, base);
    rk = 24'($urandom);
    run_ksa(rk, base);
    // Re-run with the same key: must reproduce the identical result.
    run_ksa(rk, base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
